// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: load-use stalls, branch squash, memory freeze,
// HALT drain/park. Optional perf counters when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter logic [3:0]  LOAD_OP      = 4'b1000,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      id_instr,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [3:0]       ex_rd,
    input  logic             branch_taken_ex,
    input  logic             halt_req,
    input  logic             mem_wait,
    input  logic             resume,
    output logic             stall_pc,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic             halted,
    output logic [2:0]       state_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
`endif
);

    typedef enum logic [2:0] {
        StRun    = 3'd0,
        StFlush  = 3'd1,
        StDrain  = 3'd2,
        StHalted = 3'd3
    } state_e;

    localparam logic [7:0] FlushLoad = 8'(FLUSH_CYCLES - 1);
    localparam logic [7:0] DrainLoad = 8'(DRAIN_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] fl_cnt_q, fl_cnt_d;
    logic [7:0] dr_cnt_q, dr_cnt_d;
    logic       lu;

    // Opcode field and LOAD_OP are informational only; loads are flagged by ex_mem_read.
    logic unused_id_bits;
    assign unused_id_bits = ^{id_instr[15:8], LOAD_OP};

    assign lu = ex_mem_read && (ex_rd != 4'd0) &&
                ((ex_rd == id_instr[7:4]) || (id_uses_rt && (ex_rd == id_instr[3:0])));

    assign state_o = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StRun;
            fl_cnt_q <= 8'd0;
            dr_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            fl_cnt_q <= fl_cnt_d;
            dr_cnt_q <= dr_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fl_cnt_d    = fl_cnt_q;
        dr_cnt_d    = dr_cnt_q;
        stall_pc    = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        halted      = 1'b0;
        // Outputs are gated while reset is held so hazard inputs cannot leak through.
        if (!rst) begin
            state_d = StRun;
        end else if (mem_wait) begin
            pipe_freeze = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (branch_taken_ex) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            fl_cnt_d = FlushLoad;
                            state_d  = StFlush;
                        end
                    end else if (halt_req) begin
                        stall_pc   = 1'b1;
                        ifid_hold  = 1'b1;
                        idex_flush = 1'b1;
                        if (DRAIN_CYCLES > 1) begin
                            dr_cnt_d = DrainLoad;
                            state_d  = StDrain;
                        end else begin
                            state_d = StHalted;
                        end
                    end else if (lu) begin
                        stall_pc   = 1'b1;
                        ifid_hold  = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                StFlush: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (branch_taken_ex) begin
                        fl_cnt_d = FlushLoad;
                    end else begin
                        if (fl_cnt_q != 8'd0) fl_cnt_d = fl_cnt_q - 8'd1;
                        if (fl_cnt_q <= 8'd1) state_d = StRun;
                    end
                end
                StDrain: begin
                    if (branch_taken_ex) begin
                        // Older branch resolved taken: the HALT was on the wrong path.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        dr_cnt_d   = 8'd0;
                        state_d    = StRun;
                    end else begin
                        stall_pc   = 1'b1;
                        ifid_hold  = 1'b1;
                        idex_flush = 1'b1;
                        if (dr_cnt_q != 8'd0) dr_cnt_d = dr_cnt_q - 8'd1;
                        if (dr_cnt_q <= 8'd1) state_d = StHalted;
                    end
                end
                StHalted: begin
                    pipe_freeze = 1'b1;
                    halted      = 1'b1;
                    stall_pc    = 1'b1;
                    if (resume) state_d = StRun;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            // ifid_hold marks load-use and drain stalls, excluding the parked state.
            if (ifid_hold && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
            if (mem_wait && (freeze_cnt_q != '1)) freeze_cnt_q <= freeze_cnt_q + 1'b1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage 16-bit pipeline. Drives the PC stop, IF/ID hold/flush, ID/EX bubble and global freeze controls. Covers:
- load-use stalls
- taken-branch squash
- memory-wait freeze
- HALT drain/park sequence
All controls are Mealy outputs: combinational from the FSM state plus the current hazard inputs, with zero latency. Stage registers act on them at the next clk edge.

Parameters:
LOAD_OP, 4'b1000, opcode (id_instr[15:12] encoding) of load; informational, load detection uses ex_mem_read
FLUSH_CYCLES, 1, cycles ifid_flush/idex_flush stay asserted per taken branch (1..3)
DRAIN_CYCLES, 3, bubble cycles after HALT before parking (EX/MEM/WB drain)
CNT_W, 16, width of optional performance counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
id_instr  in  16  instruction in ID; rs=[7:4], rt=[3:0]
id_uses_rt  in  1  ID instruction reads rt
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  4  destination register of EX instruction
branch_taken_ex  in  1  branch resolved taken in EX this cycle
halt_req  in  1  HALT decoded in ID
mem_wait  in  1  data memory not ready
resume  in  1  single-cycle pulse, leave HALTED
stall_pc  out  1  PC holds value
ifid_hold  out  1  IF/ID re-latches its old instruction
ifid_flush  out  1  IF/ID flush bit set (squash)
idex_flush  out  1  ID/EX loads bubble (NOP, no writes)
pipe_freeze  out  1  all stage registers hold (halt)
halted  out  1  FSM in HALTED
state_o  out  3  FSM state encoding for debug

Behaviour:
- Reset (rst=0, any time, including mid-drain or mid-flush):
  - state=RUN; flush and drain counters=0.
  - All outputs 0; state_o=3'd0.
- States: RUN=0, FLUSH=1, DRAIN=2, HALTED=3.
- Load-use hazard (lu):
  - Condition: ex_mem_read & ex_rd!=0 & (ex_rd==id_instr[7:4] | (id_uses_rt & ex_rd==id_instr[3:0])).
  - Register 0 never hazards.
- Priority, evaluated each cycle:
  1. mem_wait
  2. branch_taken_ex
  3. halt_req
  4. lu
- mem_wait=1 (any state):
  - pipe_freeze=1; all other outputs 0.
  - State and counters hold; events seen during mem_wait are ignored.
- RUN:
  - Taken branch:
    - ifid_flush=1 and idex_flush=1 this cycle.
    - If FLUSH_CYCLES>1: counter loads FLUSH_CYCLES-1 and state goes to FLUSH.
  - halt_req, no branch:
    - stall_pc=1, ifid_hold=1, idex_flush=1.
    - Drain counter loads DRAIN_CYCLES-1; state goes to DRAIN.
  - lu only:
    - stall_pc=1, ifid_hold=1, idex_flush=1 for one cycle; no state change.
    - Repeats naturally while the condition persists.
- FLUSH:
  - ifid_flush=1 and idex_flush=1; counter decrements.
  - At 0 the state returns to RUN.
  - A new taken branch reloads the counter.
  - halt_req and lu are ignored (the instruction is being squashed).
- DRAIN:
  - stall_pc=1, ifid_hold=1, idex_flush=1; counter decrements.
  - At 0 the state goes to HALTED.
  - branch_taken_ex in DRAIN comes from an older branch:
    - Squash IF/ID (ifid_flush=1) and return to RUN; the HALT is discarded.
- HALTED:
  - pipe_freeze=1, halted=1, stall_pc=1.
  - resume=1 moves the state to RUN the next cycle; outputs drop then.
  - resume outside HALTED is ignored.
- Simultaneous branch+lu: flush only, no stall. Branch+halt_req: flush wins, HALT squashed.
- Counters never wrap below 0.

Optional Feature:
HAZ_PERF_CNT_EN defined:
- Adds outputs stall_cnt[CNT_W-1:0], flush_cnt[CNT_W-1:0] and freeze_cnt[CNT_W-1:0].
- Each increments once per cycle its condition holds:
  - stall_cnt: lu stall or drain
  - flush_cnt: ifid_flush
  - freeze_cnt: mem_wait
- Counters saturate at all-ones and clear on reset.
Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Load-use on rs: ex_mem_read=1, ex_rd=4'h3, id_instr=16'h0_1_3_2 -> exactly one cycle stall_pc=ifid_hold=idex_flush=1; ex_rd=0 with same instr -> no stall.
- Branch, FLUSH_CYCLES=2: branch_taken_ex pulse -> ifid_flush/idex_flush high 2 cycles; state_o 0->1->0.
- HALT: halt_req pulse, DRAIN_CYCLES=3 -> 3 cycles stall+bubble, then halted=1, pipe_freeze=1; resume pulse -> all 0 the next cycle.
- Priority: branch_taken_ex, halt_req and lu together -> flush only, state never enters DRAIN; add mem_wait=1 -> only pipe_freeze.
- mem_wait for 4 cycles mid-DRAIN -> drain counter frozen; total cycles to HALTED = 3+4.
- Async reset asserted in DRAIN between clk edges -> outputs 0 immediately, state_o=0; if HAZ_PERF_CNT_EN, counters read 0.
